// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshake,
// branch evaluation, retire counter and HALT. Optional trap: CTRL_ILLEGAL_TRAP_EN.
module control_sequencer #(
  parameter int OPCODE_W = 4,
  parameter int SIG_W    = 12,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flag,
  input  logic                mem_ready,
  output logic [SIG_W-1:0]    signals,
  output logic [2:0]          state,
  output logic                halted,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t     st;
  logic [3:0] op_q;
  logic       rsv_q;
  logic       halted_q;
  logic       hi_nz;
  logic       rsv_in;
  logic [11:0] w;

  generate
    if (OPCODE_W > 4) begin : g_hi
      assign hi_nz = |opcode[OPCODE_W-1:4];
    end else begin : g_nohi
      assign hi_nz = 1'b0;
    end
  endgenerate

  assign rsv_in = hi_nz
                | (opcode[3:0] == 4'd13)
                | (opcode[3:0] == 4'd14);

  // Decoded instruction classes; reserved ops fall into none of them
  logic ok, is_ld, is_st, is_brz, is_jmp, is_addi, is_halt, is_alu;
  assign ok      = ~rsv_q;
  assign is_ld   = ok & (op_q == 4'd8);
  assign is_st   = ok & (op_q == 4'd9);
  assign is_addi = ok & (op_q == 4'd10);
  assign is_brz  = ok & (op_q == 4'd11);
  assign is_jmp  = ok & (op_q == 4'd12);
  assign is_halt = ok & (op_q == 4'd15);
  assign is_alu  = ok & (((op_q >= 4'd1) & (op_q <= 4'd7)) | (op_q == 4'd10));

  // Sequencer state, latched opcode, retire counter and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= S_FETCH;
      op_q     <= '0;
      rsv_q    <= 1'b0;
      halted_q <= 1'b0;
      retired  <= '0;
    end else begin
      unique case (st)
        S_FETCH: begin
          if (mem_ready) begin
            op_q  <= opcode[3:0];
            rsv_q <= rsv_in;
            st    <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_halt) begin
            st       <= S_HALT;
            halted_q <= 1'b1;
            retired  <= retired + CNT_W'(1);
          end
`ifdef CTRL_ILLEGAL_TRAP_EN
          else if (rsv_q) begin
            st <= S_TRAP;
          end
`endif
          else begin
            st <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_ld | is_st) begin
            st <= S_MEM;
          end else if (is_alu) begin
            st <= S_WB;
          end else begin
            st      <= S_FETCH;
            retired <= retired + CNT_W'(1);
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (is_ld) begin
              st <= S_WB;
            end else begin
              st      <= S_FETCH;
              retired <= retired + CNT_W'(1);
            end
          end
        end
        S_WB: begin
          st      <= S_FETCH;
          retired <= retired + CNT_W'(1);
        end
        S_HALT: st <= S_HALT;
        S_TRAP: st <= S_TRAP;
        default: st <= S_FETCH;
      endcase
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic ill_q;

  // Sticky illegal flag, raised as the reserved op enters TRAP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ill_q <= 1'b0;
    end else if (st == S_DECODE && rsv_q) begin
      ill_q <= 1'b1;
    end
  end

  assign illegal = ill_q;
`else
  assign illegal = 1'b0;
`endif

  // Control word from current state and latched opcode
  always_comb begin
    w = '0;
    unique case (st)
      S_FETCH: begin
        w[3] = 1'b1;
        w[1] = 1'b1;
        w[0] = mem_ready;
      end
      S_DECODE: w[9:6] = op_q;
      S_EXEC: begin
        w[9:6] = op_q;
        w[5]   = is_ld | is_st | is_addi;
        w[10]  = (is_brz & flag) | is_jmp;
      end
      S_MEM: begin
        w[9:6] = op_q;
        w[3]   = is_ld;
        w[4]   = is_st;
      end
      S_WB: begin
        w[9:6] = op_q;
        w[2]   = 1'b1;
      end
      S_HALT: w[11] = 1'b1;
      default: w = '0;
    endcase
  end

  assign signals = rst ? '0 : SIG_W'(w);
  assign state   = st;
  assign halted  = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer; a CNT_W=2 copy runs alongside
// the default instance to observe counter wrap.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  opcode = '0;
  logic        flag = 1'b0;
  logic        mem_ready = 1'b1;
  logic [11:0] signals, signals2;
  logic [2:0]  state, state2;
  logic        halted, halted2;
  logic        illegal, illegal2;
  logic [15:0] retired;
  logic [1:0]  retired2;

  int checks = 0;
  int failures = 0;

  control_sequencer dut (
    .clk(clk), .rst(rst), .opcode(opcode), .flag(flag),
    .mem_ready(mem_ready), .signals(signals), .state(state),
    .halted(halted), .illegal(illegal), .retired(retired)
  );

  control_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .opcode(opcode), .flag(flag),
    .mem_ready(mem_ready), .signals(signals2), .state(state2),
    .halted(halted2), .illegal(illegal2), .retired(retired2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tick until back in FETCH, bounded
  task automatic run_to_fetch(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (state != 3'd0 && n < 30);
  endtask

  int n;
  int bad;

  initial begin
    // Reset
    #12;
    check("rst_state", 32'(state), 0);
    check("rst_sig", 32'(signals), 0);
    check("rst_ret", 32'(retired), 0);
    check("rst_halt", 32'(halted), 0);
    check("rst_ill", 32'(illegal), 0);
    tick();
    rst = 1'b0;
    #1;

    // LOAD, mem_ready always 1
    opcode = 4'd8;
    mem_ready = 1'b1;
    #1;
    check("ld_fetch_st", 32'(state), 0);
    check("ld_fetch_sig", 32'(signals[4:0]), 32'h0B);
    tick();
    opcode = 4'd3;
    check("ld_dec_st", 32'(state), 1);
    check("ld_dec_sig", 32'(signals), 32'h200);
    tick();
    check("ld_exec_st", 32'(state), 2);
    check("ld_exec_sig", 32'(signals), 32'h220);
    tick();
    check("ld_mem_st", 32'(state), 3);
    check("ld_mem_sig", 32'(signals), 32'h208);
    tick();
    check("ld_wb_st", 32'(state), 4);
    check("ld_wb_sig", 32'(signals), 32'h204);
    check("ld_ret_pre", 32'(retired), 0);
    tick();
    check("ld_done_st", 32'(state), 0);
    check("ld_ret", 32'(retired), 1);

    // ALU op with 3 FETCH wait cycles
    opcode = 4'd1;
    mem_ready = 1'b0;
    #1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (state != 3'd0 || signals[3] != 1'b1 || signals[0] != 1'b0) bad++;
      tick();
    end
    check("wait_fetch_hold", 32'(bad), 0);
    mem_ready = 1'b1;
    run_to_fetch(n);
    check("wait_cycles", 32'(n + 3), 7);
    check("wait_ret", 32'(retired), 2);

    // BRZ flag=1 then flag=0
    opcode = 4'd11;
    flag = 1'b0;
    tick();
    flag = 1'b1;
    tick();
    check("brz1_exec_st", 32'(state), 2);
    check("brz1_sig", 32'(signals), 32'h6C0);
    run_to_fetch(n);
    check("brz1_cyc", 32'(n + 2), 3);
    check("brz1_ret", 32'(retired), 3);
    flag = 1'b1;
    tick();
    flag = 1'b0;
    tick();
    check("brz0_exec_st", 32'(state), 2);
    check("brz0_sig", 32'(signals), 32'h2C0);
    run_to_fetch(n);
    check("brz0_cyc", 32'(n + 2), 3);
    check("brz0_ret", 32'(retired), 4);

    // ADDI
    opcode = 4'd10;
    tick();
    tick();
    check("addi_sig", 32'(signals), 32'h2A0);
    tick();
    check("addi_wb", 32'(state), 4);
    tick();
    check("addi_ret", 32'(retired), 5);

    // Reserved opcode 13
    opcode = 4'd13;
`ifdef CTRL_ILLEGAL_TRAP_EN
    tick();
    tick();
    tick();
    tick();
    check("trap_st", 32'(state), 6);
    check("trap_ill", 32'(illegal), 1);
    check("trap_sig", 32'(signals), 0);
    check("trap_ret", 32'(retired), 5);
`else
    run_to_fetch(n);
    check("rsv_cyc", 32'(n), 3);
    check("rsv_ret", 32'(retired), 6);
    check("rsv_ill", 32'(illegal), 0);
`endif

    // Reset, then 5 NOPs on both counters
    rst = 1'b1;
    tick();
    rst = 1'b0;
    opcode = 4'd0;
    for (int i = 1; i <= 5; i++) begin
      run_to_fetch(n);
      check("nop_cyc", 32'(n), 3);
      check("nop_ret", 32'(retired), 32'(i));
      check("nop_ret2", 32'(retired2), 32'(i % 4));
    end

    // STORE aborted by reset in MEM
    opcode = 4'd9;
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    check("st_mem_st", 32'(state), 3);
    check("st_mem_sig", 32'(signals), 32'h250);
    tick();
    check("st_mem_hold", 32'(signals), 32'h250);
    check("st_mem_ret", 32'(retired), 5);
    #2;
    rst = 1'b1;
    #1;
    check("st_rst_sig", 32'(signals), 0);
    check("st_rst_st", 32'(state), 0);
    check("st_rst_ret", 32'(retired), 0);
    tick();
    rst = 1'b0;
    mem_ready = 1'b1;

    // HALT
    opcode = 4'd15;
    tick();
    tick();
    check("halt_st", 32'(state), 5);
    check("halt_bit", 32'(signals[11]), 1);
    check("halt_flag", 32'(halted), 1);
    check("halt_ret", 32'(retired), 1);
    opcode = 4'd0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (state != 3'd5 || halted != 1'b1) bad++;
    end
    check("halt_hold", 32'(bad), 0);
    check("halt_ret_hold", 32'(retired), 1);
    #2;
    rst = 1'b1;
    #1;
    check("halt_rst_st", 32'(state), 0);
    check("halt_rst_ret", 32'(retired), 0);
    check("halt_rst_h", 32'(halted), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
